pool_window_buffer: RTL

Streaming 2×2 window generator that sits directly upstream of the max-pooling stage. It accepts one feature-map pixel per valid cycle in raster order, stores one even row in a line buffer, and emits a complete non-overlapping 2×2 window (stride 2) as four signed values whenever the bottom-right pixel of a window arrives. The pooling stage consumes `win_data`/`win_valid` directly, with no backpressure.

---
 rtl/pool_window_buffer.sv | 87 ++++++++
 1 files changed

// File: rtl/pool_window_buffer.sv
// Streaming 2x2 stride-2 window generator feeding the max-pooling stage.
// One even row is kept in a line buffer; windows fire on each bottom-right pixel.
module pool_window_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         win_valid,
    output logic signed [DATA_WIDTH-1:0] win_data [3:0],
    output logic                         frame_done
);

    localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col, cur_col, left_col;
    logic [ROW_W-1:0] row, cur_row;
    logic             at_last_col, at_last_row, is_window;

    logic signed [DATA_WIDTH-1:0] line_buf [IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0] hold;

    // A start-of-frame pixel is processed as (0,0) whatever the counters say.
    always_comb begin
        cur_col     = in_sof ? '0 : col;
        cur_row     = in_sof ? '0 : row;
        left_col    = {cur_col[COL_W-1:1], 1'b0};
        at_last_col = (cur_col == LAST_COL);
        at_last_row = (cur_row == LAST_ROW);
        is_window   = in_valid && cur_row[0] && cur_col[0];
    end

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (at_last_col) begin
                col <= '0;
                row <= at_last_row ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // NOTE: line_buf and hold have no reset: each odd row reads only entries
    // rewritten by the even row just before it, so a reset would buy nothing.
    always_ff @(posedge clk) begin
        if (in_valid && !cur_row[0]) begin
            line_buf[cur_col] <= in_data;
        end
        if (in_valid && cur_row[0] && !cur_col[0]) begin
            hold <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                win_data[i] <= '0;
            end
        end else begin
            win_valid  <= is_window;
            frame_done <= in_valid && at_last_col && at_last_row;
            if (is_window) begin
                win_data[0] <= line_buf[left_col];
                win_data[1] <= line_buf[cur_col];
                win_data[2] <= hold;
                win_data[3] <= in_data;
            end
        end
    end

endmodule
